mem_rd_arb: RTL and testbench
=============================

# mem_rd_arb

Two-requester arbiter that shares the single read port of the doubleword memory between instruction fetch and the load unit (ld/ldu). It sits between the core and the memory model. It grants at most one read per cycle and tracks in-flight reads through a fixed-latency tag pipeline. It routes each returning doubleword back to its owner and keeps grant and conflict statistics for the `$display` trace.

## Interface

Parameters:
- `LATENCY`, default 1: cycles from address issue to `mem_data` valid; legal range 1..8.
- `STARVE_MAX`, default 4: consecutive denied fetch cycles after which fetch is forced to win.

Ports:
- `clk` in 1: the single clock; all state changes on posedge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: fetch wants a read; held until granted.
- `fetch_addr` in [0:60]: doubleword address.
- `fetch_gnt` out 1: combinational grant, same cycle.
- `fetch_valid` out 1: returned data belongs to fetch.
- `fetch_data` out [0:63]: returned doubleword.
- `ld_req`, `ld_addr`, `ld_gnt`, `ld_valid`, `ld_data`: same widths and meanings as the fetch set, for the load unit.
- `mem_addr` out [0:60]: address to memory; 0 when idle.
- `mem_en` out 1: a read is issued this cycle.
- `mem_data` in [0:63]: memory read data, LATENCY cycles after issue.
- `fetch_grants` out 32: count of fetch grants.
- `ld_grants` out 32: count of load grants.
- `conflicts` out 32: count of cycles in which both requesters are active.

## Operation

- Grant logic is combinational from `fetch_req`, `ld_req` and `starve_cnt`. Exactly one of `fetch_gnt`/`ld_gnt` is high when any request is active; neither is high otherwise.
- Default priority is load over fetch: a load must complete before the instruction retires.
- Starvation override: if `starve_cnt == STARVE_MAX` and `fetch_req` is high, fetch wins.
- `starve_cnt` (3 bits minimum, saturating at STARVE_MAX):
  - +1 on each cycle with `fetch_req & ~fetch_gnt`;
  - cleared on a fetch grant or when `fetch_req` is low.
- Issue path:
  - `mem_addr` is the granted requester's address;
  - `mem_en` is `fetch_gnt | ld_gnt`.
- Tag pipeline: LATENCY stages, each holding {valid, owner}.
  - Stage 0 is loaded every cycle with {`mem_en`, `ld_gnt`}.
  - At the output stage, `fetch_valid` = valid & ~owner and `ld_valid` = valid & owner.
- Data: `fetch_data` and `ld_data` are driven from `mem_data` when their valid is high, and 0 otherwise.
- Counters:
  - `fetch_grants` +1 on `fetch_gnt`; `ld_grants` +1 on `ld_gnt`;
  - `conflicts` +1 when `fetch_req & ld_req`;
  - all are 32-bit and wrap from 0xFFFFFFFF to 0.
- A requester may drop `req` in any non-granted cycle with no side effect. An address change while not granted is legal.

## Timing

- Reset values:
  - both grants 0, `mem_en` 0, `mem_addr` 0;
  - both valids 0, both data outputs 0;
  - `starve_cnt` 0, all tag stages invalid, all counters 0.
- Grant latency is 0 cycles: a grant is asserted in the cycle of the request if that requester wins.
- Response latency: a grant in cycle N gives the matching valid in cycle N+LATENCY, high for exactly 1 cycle.
- Throughput is one read per cycle. Back-to-back grants produce back-to-back valids in grant order.
- Simultaneous requests with `starve_cnt < STARVE_MAX`: load wins, fetch is denied, `starve_cnt` increments, and `conflicts` increments.
- Reset asserted mid-flight: all tags are cleared at that edge, and no valid appears for reads issued before reset. Grants are suppressed during the reset cycle.
- Reset has priority over counter wrap and the saturating counter.

## Configuration

- `MEM_RD_ARB_STARVE_EN` defined: the starvation override and `starve_cnt` are present as described above.
- Undefined: strict load-over-fetch priority. `starve_cnt` is not implemented, and fetch is granted only when `ld_req` is low.
- Counters and the tag pipeline are identical in both builds.

## Test plan

- Idle after reset: hold `reset` for 2 cycles, no requests. Required: all outputs 0 and all counters 0.
- Single fetch, LATENCY=1: `fetch_req`=1, `fetch_addr`=0x10 in cycle 3. Required: `fetch_gnt`=1 and `mem_addr`=0x10 in cycle 3; `fetch_valid`=1 with `fetch_data`=mem[0x10] in cycle 4; `fetch_grants`=1.
- Conflict, STARVE_MAX=4, macro defined: both requesting continuously. Required: `ld_gnt` in cycles 0-3, `fetch_gnt` in cycle 4, `ld_gnt` in cycle 5; `conflicts`=6 after cycle 5. Without the macro: `ld_gnt` in all 6 cycles and `fetch_grants`=0.
- Pipelined, LATENCY=3: load grants at addresses 0x1, 0x2, 0x3 in cycles 0-2. Required: `ld_valid` in cycles 3-5 with data mem[0x1], mem[0x2], mem[0x3] in order; `fetch_valid` stays 0.
- Reset mid-flight, LATENCY=3: fetch grant in cycle 0, `reset` high in cycle 1. Required: no `fetch_valid` in cycle 3; `fetch_grants`=0 after reset.
- Wrap: preload `ld_grants`=0xFFFFFFFF via force, then one load grant. Required: `ld_grants`=0.

Source files
------------

// File: rtl/mem_rd_arb.sv
// Read-port arbiter between instruction fetch and the load unit, with a fixed-latency
// tag pipeline that steers returning data to its owner. Define MEM_RD_ARB_STARVE_EN to add fetch starvation override.
module mem_rd_arb #(
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [0:60] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [0:63] fetch_data,
  input  logic        ld_req,
  input  logic [0:60] ld_addr,
  output logic        ld_gnt,
  output logic        ld_valid,
  output logic [0:63] ld_data,
  output logic [0:60] mem_addr,
  output logic        mem_en,
  input  logic [0:63] mem_data,
  output logic [31:0] fetch_grants,
  output logic [31:0] ld_grants,
  output logic [31:0] conflicts
);

  if (LATENCY < 1 || LATENCY > 8 || STARVE_MAX < 1) begin : gBadParams
    $error("mem_rd_arb: LATENCY must be 1..8 and STARVE_MAX at least 1");
  end

  logic fetchWin;
  logic ldWin;

`ifdef MEM_RD_ARB_STARVE_EN
  localparam int STARVE_W = (STARVE_MAX < 8) ? 3 : $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starveCnt;
  logic [STARVE_W-1:0] starveNext;
  logic                starveForce;

  assign starveForce = (starveCnt == STARVE_W'(STARVE_MAX));

  // Load normally wins; a fetch denied STARVE_MAX times in a row takes the port.
  always_comb begin
    fetchWin = 1'b0;
    ldWin    = 1'b0;
    if (!reset) begin
      if (fetch_req && (starveForce || !ld_req)) begin
        fetchWin = 1'b1;
      end else if (ld_req) begin
        ldWin = 1'b1;
      end
    end
  end

  always_comb begin
    starveNext = starveCnt;
    if (!fetch_req || fetchWin) begin
      starveNext = '0;
    end else if (!starveForce) begin
      starveNext = starveCnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starveCnt <= '0;
    end else begin
      starveCnt <= starveNext;
    end
  end
`else
  // Strict load-over-fetch priority.
  always_comb begin
    fetchWin = 1'b0;
    ldWin    = 1'b0;
    if (!reset) begin
      if (ld_req) begin
        ldWin = 1'b1;
      end else if (fetch_req) begin
        fetchWin = 1'b1;
      end
    end
  end
`endif

  assign fetch_gnt = fetchWin;
  assign ld_gnt    = ldWin;
  assign mem_en    = fetchWin | ldWin;

  always_comb begin
    mem_addr = '0;
    if (fetchWin) begin
      mem_addr = fetch_addr;
    end else if (ldWin) begin
      mem_addr = ld_addr;
    end
  end

  // Each stage carries {valid, owner}; owner 1 means the load unit.
  logic [LATENCY-1:0] tagValid;
  logic [LATENCY-1:0] tagOwner;

  always_ff @(posedge clk) begin
    if (reset) begin
      tagValid <= '0;
      tagOwner <= '0;
    end else begin
      tagValid[0] <= mem_en;
      tagOwner[0] <= ldWin;
      for (int i = 1; i < LATENCY; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagOwner[i] <= tagOwner[i-1];
      end
    end
  end

  assign fetch_valid = tagValid[LATENCY-1] & ~tagOwner[LATENCY-1];
  assign ld_valid    = tagValid[LATENCY-1] &  tagOwner[LATENCY-1];
  assign fetch_data  = fetch_valid ? mem_data : '0;
  assign ld_data     = ld_valid    ? mem_data : '0;

  logic [31:0] fetchGrantCount;
  logic [31:0] ldGrantCount;
  logic [31:0] conflictCount;

  // Statistics counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchGrantCount <= '0;
      ldGrantCount    <= '0;
      conflictCount   <= '0;
    end else begin
      if (fetchWin) begin
        fetchGrantCount <= fetchGrantCount + 32'd1;
      end
      if (ldWin) begin
        ldGrantCount <= ldGrantCount + 32'd1;
      end
      if (fetch_req && ld_req) begin
        conflictCount <= conflictCount + 32'd1;
      end
    end
  end

  assign fetch_grants = fetchGrantCount;
  assign ld_grants    = ldGrantCount;
  assign conflicts    = conflictCount;

endmodule

// File: tb/tb_mem_rd_arb.sv
// Scoreboard bench for mem_rd_arb: directed request vectors push expected responses,
// a negedge monitor pops them when the arbiter returns data.
module tb_mem_rd_arb;

  localparam int LAT  = 3;
  localparam int SMAX = 4;
`ifdef MEM_RD_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [0:60] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [0:63] fetch_data;
  logic        ld_req;
  logic [0:60] ld_addr;
  logic        ld_gnt;
  logic        ld_valid;
  logic [0:63] ld_data;
  logic [0:60] mem_addr;
  logic        mem_en;
  logic [0:63] mem_data;
  logic [31:0] fetch_grants;
  logic [31:0] ld_grants;
  logic [31:0] conflicts;

  mem_rd_arb #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .fetch_grants(fetch_grants), .ld_grants(ld_grants), .conflicts(conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit monitorOn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [0:63] memWord(input logic [0:60] a);
    return {a, 3'b101} ^ 64'hC3A5_0F1E_9D2B_4786;
  endfunction

  // Memory model: returns the word for the address issued LAT cycles earlier.
  logic [0:60] addrPipe [LAT];
  initial for (int i = 0; i < LAT; i++) addrPipe[i] = '0;
  always @(posedge clk) begin
    addrPipe[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) addrPipe[i] <= addrPipe[i-1];
  end
  assign mem_data = memWord(addrPipe[LAT-1]);

  typedef struct {
    logic        owner;
    logic [0:60] addr;
    int          due;
  } rsp_t;

  rsp_t sb[$];
  rsp_t monRsp;

  logic [31:0] expFetchGrants = '0;
  logic [31:0] expLdGrants = '0;
  logic [31:0] expConflicts = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%h, expected 0x%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: a response is due exactly LAT cycles after its grant; otherwise outputs stay quiet.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        monRsp = sb.pop_front();
        checkOutput("fetch_valid", {63'd0, fetch_valid}, {63'd0, !monRsp.owner});
        checkOutput("ld_valid", {63'd0, ld_valid}, {63'd0, monRsp.owner});
        if (monRsp.owner) begin
          checkOutput("ld_data", ld_data, memWord(monRsp.addr));
          checkOutput("fetch_data quiet", fetch_data, 64'd0);
        end else begin
          checkOutput("fetch_data", fetch_data, memWord(monRsp.addr));
          checkOutput("ld_data quiet", ld_data, 64'd0);
        end
      end else begin
        checkOutput("fetch_valid idle", {63'd0, fetch_valid}, 64'd0);
        checkOutput("ld_valid idle", {63'd0, ld_valid}, 64'd0);
        checkOutput("fetch_data idle", fetch_data, 64'd0);
        checkOutput("ld_data idle", ld_data, 64'd0);
      end
    end
  end

  task automatic applyStimulus(input logic fr, input logic [0:60] fa, input logic lr,
                               input logic [0:60] la, input logic expF, input logic expL,
                               input string name);
    rsp_t r;
    @(posedge clk); #1;
    fetch_req  = fr;
    fetch_addr = fa;
    ld_req     = lr;
    ld_addr    = la;
    @(negedge clk);
    checkOutput({name, " fetch_gnt"}, {63'd0, fetch_gnt}, {63'd0, expF});
    checkOutput({name, " ld_gnt"}, {63'd0, ld_gnt}, {63'd0, expL});
    checkOutput({name, " mem_en"}, {63'd0, mem_en}, {63'd0, expF | expL});
    checkOutput({name, " mem_addr"}, {3'd0, mem_addr}, expF ? {3'd0, fa} : (expL ? {3'd0, la} : 64'd0));
    if (expF || expL) begin
      r.owner = expL;
      r.addr  = expF ? fa : la;
      r.due   = cyc + LAT;
      sb.push_back(r);
    end
    if (expF) expFetchGrants++;
    if (expL) expLdGrants++;
    if (fr && lr) expConflicts++;
  endtask

  task automatic checkCounters(input string name);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    ld_req    = 1'b0;
    checkOutput({name, " fetch_grants"}, {32'd0, fetch_grants}, {32'd0, expFetchGrants});
    checkOutput({name, " ld_grants"}, {32'd0, ld_grants}, {32'd0, expLdGrants});
    checkOutput({name, " conflicts"}, {32'd0, conflicts}, {32'd0, expConflicts});
    @(negedge clk);
    checkOutput({name, " idle gnts"}, {62'd0, fetch_gnt, ld_gnt}, 64'd0);
    checkOutput({name, " idle mem_en"}, {63'd0, mem_en}, 64'd0);
    checkOutput({name, " idle mem_addr"}, {3'd0, mem_addr}, 64'd0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      fetch_req = 1'b0;
      ld_req    = 1'b0;
    end
  endtask

  // Reads still in flight when reset rises are dropped unless due in that very cycle.
  task automatic doReset(input int n, input logic holdFetch);
    @(posedge clk); #1;
    reset     = 1'b1;
    fetch_req = holdFetch;
    ld_req    = 1'b0;
    while (sb.size() != 0 && sb[$].due > cyc) void'(sb.pop_back());
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("reset fetch_gnt", {63'd0, fetch_gnt}, 64'd0);
      checkOutput("reset ld_gnt", {63'd0, ld_gnt}, 64'd0);
      checkOutput("reset mem_en", {63'd0, mem_en}, 64'd0);
      checkOutput("reset mem_addr", {3'd0, mem_addr}, 64'd0);
      @(posedge clk); #1;
    end
    reset          = 1'b0;
    fetch_req      = 1'b0;
    expFetchGrants = '0;
    expLdGrants    = '0;
    expConflicts   = '0;
    monitorOn      = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    fetch_req  = 1'b0;
    ld_req     = 1'b0;
    fetch_addr = '0;
    ld_addr    = '0;

    doReset(2, 1'b0);
    checkCounters("idle after reset");

    applyStimulus(1'b1, 61'h10, 1'b0, 61'h0, 1'b1, 1'b0, "single fetch");
    checkCounters("single fetch");
    idleCycles(LAT);

    doReset(1, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 61'h40, 1'b1, 61'(32'h20 + i), STARVE_ON && (i == 4),
                    !(STARVE_ON && (i == 4)), "conflict");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 61'h40, 1'b1, 61'(32'h30 + i), 1'b0, 1'b1, "starve build");
    applyStimulus(1'b0, 61'h40, 1'b1, 61'h33, 1'b0, 1'b1, "fetch drop");
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 61'h40, 1'b1, 61'(32'h34 + i), 1'b0, 1'b1, "starve cleared");
    applyStimulus(1'b1, 61'h40, 1'b0, 61'h0, 1'b1, 1'b0, "fetch alone");
    checkCounters("conflict");
    idleCycles(LAT);

    for (int i = 1; i <= 3; i++)
      applyStimulus(1'b0, 61'h0, 1'b1, 61'(i), 1'b0, 1'b1, "pipelined ld");
    applyStimulus(1'b1, 61'h5, 1'b0, 61'h0, 1'b1, 1'b0, "mixed fetch");
    applyStimulus(1'b0, 61'h0, 1'b1, 61'h6, 1'b0, 1'b1, "mixed ld");
    applyStimulus(1'b1, 61'h7, 1'b0, 61'h0, 1'b1, 1'b0, "mixed fetch2");
    checkCounters("pipelined");
    idleCycles(LAT);

    applyStimulus(1'b1, 61'h50, 1'b0, 61'h0, 1'b1, 1'b0, "mid-flight fetch");
    doReset(1, 1'b1);
    checkCounters("after mid-flight reset");
    idleCycles(LAT + 1);

    @(negedge clk);
    force dut.ldGrantCount = 32'hFFFF_FFFF;
    #1;
    release dut.ldGrantCount;
    expLdGrants = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 61'h0, 1'b1, 61'h77, 1'b0, 1'b1, "wrap");
    checkCounters("wrap");
    idleCycles(LAT + 1);

    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
